// File: rtl/uart_line_buffer.sv
// uart_line_buffer: collects rx bytes into an editable line and replays it with CR LF on EOL
// Ports: clk, rst_n (sync, active-low); rx_valid/rx_data incoming byte strobe;
//        tx_valid/tx_ready/tx_data outgoing handshake; line_len length of last line;
//        overflow sticky drop flag, ovf_clr clears it; busy high while replaying.
module uart_line_buffer #(
    parameter int          DEPTH  = 64,
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  EOL    = 8'h0D,
    parameter logic [7:0]  BS     = 8'h08
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic [ADDR_W:0]   line_len,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy
);
    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] EMIT    = 2'd1;
    localparam logic [1:0] EMIT_CR = 2'd2;
    localparam logic [1:0] EMIT_LF = 2'd3;
    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        mem [DEPTH];
    logic is_bs, is_lf, is_eol, is_char, full, xfer, wr, drop;
    assign is_bs   = rx_data == BS || rx_data == 8'h7F;
    assign is_lf   = rx_data == 8'h0A;
    assign is_eol  = rx_data == EOL;
    assign is_char = !is_bs && !is_lf && !is_eol;
    assign full    = count == (ADDR_W+1)'(DEPTH);
    assign busy    = state != COLLECT;
    assign xfer    = tx_valid && tx_ready;
    assign wr      = rx_valid && !busy && is_char && !full;
    // any byte arriving during replay is lost, as is a printable byte into a full line
    assign drop    = rx_valid && (busy || (is_char && full));
    always_ff @(posedge clk)
        if (wr) mem[count[ADDR_W-1:0]] <= rx_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= COLLECT;
            count    <= '0;
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            line_len <= '0;
            overflow <= 1'b0;
        end else begin
            // a drop in the same cycle as ovf_clr leaves overflow set
            if (ovf_clr) overflow <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state)
                COLLECT: if (rx_valid) begin
                    if (is_bs) begin
                        if (count != 0) count <= count - 1'b1;
                    end else if (is_eol) begin
                        line_len <= count;
                        rd_ptr   <= '0;
                        tx_valid <= 1'b1;
                        state    <= count != 0 ? EMIT : EMIT_CR;
                        tx_data  <= count != 0 ? mem[0] : 8'h0D;
                    end else if (wr) begin
                        count <= count + 1'b1;
                    end
                end
                EMIT: if (xfer) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if ({1'b0, rd_ptr} == count - 1'b1) begin
                        state   <= EMIT_CR;
                        tx_data <= 8'h0D;
                    end else begin
                        tx_data <= mem[rd_ptr + 1'b1];
                    end
                end
                EMIT_CR: if (xfer) begin
                    state   <= EMIT_LF;
                    tx_data <= 8'h0A;
                end
                default: if (xfer) begin
                    state    <= COLLECT;
                    tx_valid <= 1'b0;
                    count    <= '0;
                    rd_ptr   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_line_buffer.md
Name: uart_line_buffer

Overview:
- Line-editing stage directly downstream of the UART receiver and upstream of the UART transmitter.
- Collects received bytes into a line buffer, applying backspace editing, until a carriage return arrives.
- Then replays the completed line to the transmitter, followed by CR LF.
- Replaces the per-byte echo path with line-granular echo for the command interface.

Parameters:
- DEPTH, 64, line buffer capacity in bytes; must be a power of 2.
- ADDR_W, 6, log2(DEPTH).
- EOL, 8'h0D, line terminator byte.
- BS, 8'h08, backspace byte. 8'h7F is always treated as backspace too.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- rx_valid  input  1  one-cycle strobe, rx_data valid (already in clk domain).
- rx_data  input  8  received byte.
- tx_valid  output  1  tx_data valid, held until accepted.
- tx_ready  input  1  transmitter can accept a byte this cycle.
- tx_data  output  8  byte to transmit.
- line_len  output  ADDR_W+1  length of the last completed line (excludes EOL).
- overflow  output  1  sticky: a byte was dropped.
- ovf_clr  input  1  clears overflow.
- busy  output  1  high while replaying a line (state != COLLECT).

Behaviour:
- Reset (rst_n low at a posedge):
  - state=COLLECT, count=0, rd_ptr=0.
  - tx_valid=0, tx_data=0, line_len=0, overflow=0, busy=0.
  - Reset mid-replay aborts the line; tx_valid is low the cycle after reset.
- Transfer rule:
  - A tx byte transfers on a posedge where tx_valid && tx_ready.
  - While tx_valid=1 and not yet accepted, tx_data must not change.
  - tx_valid=0 in COLLECT.
- State COLLECT, on rx_valid:
  - rx_data==BS or 8'h7F: if count>0, count--; otherwise ignored.
  - rx_data==8'h0A: ignored, so CRLF terminals do not create empty lines.
  - rx_data==EOL: line_len<=count, rd_ptr<=0. Go to EMIT if count>0, else EMIT_CR.
  - Any other byte: if count<DEPTH, mem[count]<=rx_data and count++; otherwise drop and set overflow.
- State EMIT:
  - tx_valid=1, tx_data=mem[rd_ptr].
  - On transfer: rd_ptr++.
  - If rd_ptr==count-1 at the transfer, go to EMIT_CR.
- State EMIT_CR: tx_valid=1, tx_data=8'h0D; on transfer go to EMIT_LF.
- State EMIT_LF:
  - tx_valid=1, tx_data=8'h0A.
  - On transfer go to COLLECT with count=0 and rd_ptr=0.
  - tx_valid is low the following cycle.
- Latency:
  - EOL strobe at posedge N gives tx_valid=1 with the first byte visible after posedge N+1 (registered output).
  - With tx_ready held high, one byte transfers per cycle back-to-back; no bubbles between bytes, CR, and LF.
- rx_valid while busy: byte dropped and overflow set. Incoming bytes are never queued.
- overflow:
  - Set by any drop.
  - Cleared only by ovf_clr or reset.
  - Drop and ovf_clr in the same cycle: overflow ends at 1 (set wins).
- Full line: count==DEPTH is legal. EOL then replays all DEPTH bytes and line_len=DEPTH, which needs the ADDR_W+1 width. count never wraps.
- busy is combinational from state: 1 in EMIT, EMIT_CR, and EMIT_LF.
- mem has no reset; contents are only read below count.

Test Plan:
- "Hi" + CR with tx_ready=1 -> tx sequence 48,69,0D,0A on 4 consecutive cycles starting the cycle after CR; line_len=2; busy low after LF.
- "abX" + 08 + 7F + "c" + CR -> tx 61,63,0D,0A; line_len=2. Backspace at count=0 -> no change, no underflow.
- Lone CR, also CR LF pair -> tx 0D,0A only; the LF received afterwards is ignored; line_len=0.
- 65 bytes 0x41 then CR with DEPTH=64 -> overflow=1; 64 bytes of 0x41 then 0D,0A replayed; line_len=64. Pulse ovf_clr -> overflow=0.
- Replay with tx_ready toggling 1,0,0,1 -> tx_data stable while stalled; no byte skipped or duplicated. rx_valid during replay -> byte dropped, overflow=1.
- rst_n low two cycles into replay of "test" -> tx_valid=0 next cycle; then "ok"+CR -> exactly 6F,6B,0D,0A.
